// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures bytes from a level-handshake receiver
// into a first-word fall-through buffer with fill-level interrupt.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_irq,
  input  logic [7:0]        rx_data,
  output logic              rx_read,
  input  logic              pop,
  input  logic              fifo_clr,
  input  logic              irq_en,
  input  logic [ADDR_W:0]   thresh,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t state;
  state_t state_next;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   thr;
  logic              push;
  logic              do_pop;
  logic              read_next;
  logic              ovr_set;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = mem[rd_ptr];
  assign thr     = (thresh == '0) ? CNT_ONE : thresh;
  assign do_pop  = pop && !empty && !fifo_clr;

  // A flush freezes the handshake so no byte is written or acked that cycle.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    read_next  = 1'b0;
    ovr_set    = 1'b0;
    if (!fifo_clr) begin
      unique case (state)
        IDLE: begin
          if (rx_irq) begin
            if (!full) begin
              push       = 1'b1;
              read_next  = 1'b1;
              state_next = ACK;
            end else begin
              ovr_set = 1'b1;
            end
          end
        end
        ACK:      state_next = WAIT_LOW;
        WAIT_LOW: if (!rx_irq) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rx_read <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_next;
      rx_read <= read_next;
      irq     <= irq_en & ((count >= thr) | overrun);
      if (fifo_clr) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        overrun <= 1'b0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
        unique case ({push, do_pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
        if (ovr_set) overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a byte scoreboard
// and a table of interrupt threshold vectors.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_irq;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       pop;
  logic       fifo_clr;
  logic       irq_en;
  logic [4:0] thresh;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       irq;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];
  logic       prev_read = 1'b0;

  typedef struct {
    logic [4:0] thr;
    logic       en;
    int         n;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[7];

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .rx_irq(rx_irq), .rx_data(rx_data), .rx_read(rx_read),
    .pop(pop), .fifo_clr(fifo_clr),
    .irq_en(irq_en), .thresh(thresh),
    .rd_data(rd_data), .count(count),
    .empty(empty), .full(full),
    .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // rx_read must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (rx_read) begin
      checks++;
      if (prev_read) begin
        failures++;
        $display("FAIL rx_read_consecutive actual=1 required=0");
      end
    end
    prev_read <= rx_read;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit acked = 0;
    rx_irq  = 1'b1;
    rx_data = b;
    for (int i = 0; i < 8 && !acked; i++) begin
      tick();
      if (rx_read) acked = 1;
    end
    check("send_ack", 32'(acked), 1);
    if (acked) sb.push_back(b);
    rx_irq = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_one(input string name);
    logic [7:0] e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=pop required=scoreboard_entry", name);
    end else begin
      e = sb.pop_front();
      check(name, rd_data, e);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic clear();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    tick();
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd4,  1'b1, 3,  1'b0};
    vecs[1] = '{5'd4,  1'b1, 4,  1'b1};
    vecs[2] = '{5'd0,  1'b1, 1,  1'b1};
    vecs[3] = '{5'd0,  1'b1, 0,  1'b0};
    vecs[4] = '{5'd2,  1'b0, 5,  1'b0};
    vecs[5] = '{5'd16, 1'b1, 15, 1'b0};
    vecs[6] = '{5'd16, 1'b1, 16, 1'b1};

    rst = 1'b1; rx_irq = 1'b0; rx_data = '0; pop = 1'b0;
    fifo_clr = 1'b0; irq_en = 1'b0; thresh = '0;
    tick(); tick(); tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rx_read", rx_read, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;
    tick();

    // single byte handshake
    rx_irq = 1'b1; rx_data = 8'hA5;
    tick();
    check("one_rx_read", rx_read, 1);
    check("one_count", count, 1);
    check("one_rd_data", rd_data, 8'hA5);
    check("one_empty", empty, 0);
    rx_irq = 1'b0;
    tick();
    check("one_rx_read_low", rx_read, 0);
    tick();
    sb.push_back(8'hA5);
    pop_one("one_pop");
    check("one_empty_after", empty, 1);

    // fill to full, overrun, stalled byte resumes after a pop
    clear();
    for (int i = 0; i < 16; i++) send(8'(i));
    check("full_flag", full, 1);
    check("full_count", count, 16);
    rx_irq = 1'b1; rx_data = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_withheld", rx_read, 0);
    end
    check("full_overrun", overrun, 1);
    check("full_count_hold", count, 16);
    pop_one("full_pop0");
    check("full_pop_count", count, 15);
    check("full_pop_no_push", rx_read, 0);
    tick();
    check("full_resume_read", rx_read, 1);
    check("full_resume_count", count, 16);
    sb.push_back(8'h10);
    rx_irq = 1'b0;
    tick(); tick();
    for (int i = 0; i < 16; i++) pop_one("full_order");
    check("full_drained", empty, 1);
    check("full_overrun_sticky", overrun, 1);
    clear();
    check("clr_overrun", overrun, 0);

    // wrap-around
    for (int i = 0; i < 10; i++) send(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) pop_one("wrap_pop_a");
    for (int i = 0; i < 12; i++) send(8'(8'h40 + i));
    check("wrap_count", count, 12);
    for (int i = 0; i < 12; i++) pop_one("wrap_pop_b");

    // simultaneous push and pop, then underflow attempt
    clear();
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i));
    check("sim_count_pre", count, 5);
    check("sim_head", rd_data, sb.pop_front());
    rx_irq = 1'b1; rx_data = 8'h77; pop = 1'b1;
    tick();
    pop = 1'b0;
    check("sim_read", rx_read, 1);
    check("sim_count", count, 5);
    sb.push_back(8'h77);
    rx_irq = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) pop_one("sim_pop");
    pop = 1'b1;
    tick(); tick();
    pop = 1'b0;
    check("under_count", count, 0);
    check("under_empty", empty, 1);

    // threshold table
    foreach (vecs[k]) begin
      clear();
      irq_en = vecs[k].en;
      thresh = vecs[k].thr;
      for (int i = 0; i < vecs[k].n; i++) send(8'(i));
      tick();
      check($sformatf("tbl%0d_count", k), count, 32'(vecs[k].n));
      check($sformatf("tbl%0d_irq", k), irq, 32'(vecs[k].exp_irq));
    end

    // irq latency on the threshold-crossing push, then flush
    clear();
    irq_en = 1'b1; thresh = 5'd4;
    for (int i = 0; i < 3; i++) send(8'(i));
    check("lat_irq_3", irq, 0);
    rx_irq = 1'b1; rx_data = 8'h03;
    tick();
    check("lat_read", rx_read, 1);
    check("lat_count", count, 4);
    check("lat_irq_same", irq, 0);
    tick();
    check("lat_irq_next", irq, 1);
    rx_irq = 1'b0;
    tick(); tick();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    check("flush_count", count, 0);
    check("flush_overrun", overrun, 0);
    tick();
    check("flush_irq", irq, 0);
    sb.delete();

    // reset during ACK with rx_irq held high
    rx_irq = 1'b1; rx_data = 8'h5C;
    tick();
    check("ackrst_read", rx_read, 1);
    rst = 1'b1;
    tick();
    check("ackrst_rx_read", rx_read, 0);
    check("ackrst_count", count, 0);
    check("ackrst_empty", empty, 1);
    check("ackrst_full", full, 0);
    check("ackrst_overrun", overrun, 0);
    check("ackrst_irq", irq, 0);
    rst = 1'b0;
    tick();
    check("recap_read", rx_read, 1);
    check("recap_count", count, 1);
    check("recap_data", rd_data, 8'h5C);
    rx_irq = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
